// File: rtl/fechadura_pkg.sv
// Shared types and default timing constants for the combination lock and its supervisor.
package fechadura_pkg;

  typedef enum logic [1:0] {
    OCIOSO    = 2'd0,
    ABERTO    = 2'd1,
    BLOQUEADO = 2'd2
  } estado_alarme_t;

  localparam int MAX_ERROS_PAD    = 3;
  localparam int ABRE_CICLOS_PAD  = 8;
  localparam int BLOQ_CICLOS_PAD  = 16;
  localparam int PISCA_CICLOS_PAD = 4;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/detector_borda.sv
// 1-bit rising-edge detector: pulses for the first cycle an input is seen high.
module detector_borda (
  input  logic clock,
  input  logic reset_n,
  input  logic entrada,
  output logic borda
);

  logic anterior;

  always_ff @(posedge clock) begin
    if (!reset_n) anterior <= 1'b0;
    else          anterior <= entrada;
  end

  assign borda = entrada & ~anterior;

endmodule

// File: rtl/alarme_fechadura.sv
// Lock supervisor: door-release timing, consecutive-failure count and timed lockout with blinking alarm.
module alarme_fechadura
  import fechadura_pkg::*;
#(
  parameter int MAX_ERROS    = MAX_ERROS_PAD,
  parameter int ABRE_CICLOS  = ABRE_CICLOS_PAD,
  parameter int BLOQ_CICLOS  = BLOQ_CICLOS_PAD,
  parameter int PISCA_CICLOS = PISCA_CICLOS_PAD
) (
  input  logic                             clock,
  input  logic                             reset_n,
  input  logic                             led_vermelho,
  input  logic                             led_verde,
  output logic                             porta_aberta,
  output logic                             bloqueado,
  output logic                             alarme,
  output logic [$clog2(MAX_ERROS+1)-1:0]   erros
);

  localparam int EW = $clog2(MAX_ERROS+1);
  localparam int TW = $clog2(max_int(ABRE_CICLOS, BLOQ_CICLOS));
  localparam int BW = max_int(1, $clog2(PISCA_CICLOS));

  localparam logic [TW-1:0] ABRE_CARGA = TW'(ABRE_CICLOS-1);
  localparam logic [TW-1:0] BLOQ_CARGA = TW'(BLOQ_CICLOS-1);
  localparam logic [TW-1:0] T_UM       = TW'(1);
  localparam logic [BW-1:0] PISCA_FIM  = BW'(PISCA_CICLOS-1);
  localparam logic [BW-1:0] P_UM       = BW'(1);
  localparam logic [EW-1:0] E_UM       = EW'(1);

  estado_alarme_t estado, prox_estado;
  logic [TW-1:0]  timer, prox_timer;
  logic [BW-1:0]  pisca_cnt, prox_pisca;
  logic [EW-1:0]  erros_q, prox_erros;
  logic           alarme_q, prox_alarme;
  logic           ev_verm, ev_verde;

  detector_borda u_borda_verm (
    .clock(clock), .reset_n(reset_n), .entrada(led_vermelho), .borda(ev_verm)
  );
  detector_borda u_borda_verde (
    .clock(clock), .reset_n(reset_n), .entrada(led_verde), .borda(ev_verde)
  );

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      estado    <= OCIOSO;
      timer     <= '0;
      pisca_cnt <= '0;
      erros_q   <= '0;
      alarme_q  <= 1'b0;
    end else begin
      estado    <= prox_estado;
      timer     <= prox_timer;
      pisca_cnt <= prox_pisca;
      erros_q   <= prox_erros;
      alarme_q  <= prox_alarme;
    end
  end

  // A red event always wins over a simultaneous green one (fail-safe).
  always_comb begin
    prox_estado = estado;
    prox_timer  = timer;
    prox_pisca  = pisca_cnt;
    prox_erros  = erros_q;
    prox_alarme = alarme_q;
    case (estado)
      OCIOSO: begin
        if (ev_verm) begin
          if (int'(erros_q) + 1 < MAX_ERROS) begin
            prox_erros = erros_q + E_UM;
          end else begin
            prox_estado = BLOQUEADO;
            prox_timer  = BLOQ_CARGA;
            prox_erros  = '0;
            prox_pisca  = '0;
            prox_alarme = 1'b1;
          end
        end else if (ev_verde) begin
          prox_estado = ABERTO;
          prox_timer  = ABRE_CARGA;
          prox_erros  = '0;
        end
      end
      ABERTO: begin
        if (ev_verm) begin
          if (MAX_ERROS == 1) begin
            prox_estado = BLOQUEADO;
            prox_timer  = BLOQ_CARGA;
            prox_erros  = '0;
            prox_pisca  = '0;
            prox_alarme = 1'b1;
          end else begin
            prox_estado = OCIOSO;
            prox_erros  = E_UM;
          end
        end else if (ev_verde) begin
          prox_timer = ABRE_CARGA;
        end else if (timer == '0) begin
          prox_estado = OCIOSO;
        end else begin
          prox_timer = timer - T_UM;
        end
      end
      BLOQUEADO: begin
        if (pisca_cnt == PISCA_FIM) begin
          prox_pisca  = '0;
          prox_alarme = ~alarme_q;
        end else begin
          prox_pisca = pisca_cnt + P_UM;
        end
        if (timer == '0) begin
          prox_estado = OCIOSO;
          prox_alarme = 1'b0;
          prox_pisca  = '0;
        end else begin
          prox_timer = timer - T_UM;
        end
      end
      default: prox_estado = OCIOSO;
    endcase
  end

  always_comb begin
    porta_aberta = (estado == ABERTO);
    bloqueado    = (estado == BLOQUEADO);
    alarme       = alarme_q & (estado == BLOQUEADO);
    erros        = erros_q;
  end

endmodule

// File: tb/tb_alarme_fechadura.sv
// Directed bench for alarme_fechadura with a cycle-count reference model and literal spot checks.
module tb_alarme_fechadura;

  localparam int MAXE  = 3;
  localparam int ABRE  = 8;
  localparam int BLOQ  = 16;
  localparam int PISCA = 4;

  logic       clock = 1'b0;
  logic       reset_n = 1'b0;
  logic       led_vermelho = 1'b0;
  logic       led_verde = 1'b0;
  logic       porta_aberta, bloqueado, alarme;
  logic [1:0] erros;

  int checks = 0;
  int failures = 0;

  alarme_fechadura #(
    .MAX_ERROS(MAXE), .ABRE_CICLOS(ABRE), .BLOQ_CICLOS(BLOQ), .PISCA_CICLOS(PISCA)
  ) dut (
    .clock(clock), .reset_n(reset_n), .led_vermelho(led_vermelho), .led_verde(led_verde),
    .porta_aberta(porta_aberta), .bloqueado(bloqueado), .alarme(alarme), .erros(erros)
  );

  always #5 clock = ~clock;

  // Reference model: remaining door/lockout cycles, elapsed lockout cycles, error count.
  int m_porta = 0, m_bloq = 0, m_decor = 0, m_erros = 0;
  bit m_pv = 0, m_pg = 0;

  always @(posedge clock) begin
    bit r, g;
    if (!reset_n) begin
      m_porta = 0; m_bloq = 0; m_decor = 0; m_erros = 0; m_pv = 0; m_pg = 0;
    end else begin
      r = led_vermelho && !m_pv;
      g = led_verde && !m_pg;
      m_pv = led_vermelho;
      m_pg = led_verde;
      if (m_bloq > 0) begin
        m_bloq--;
        m_decor++;
      end else if (r) begin
        m_porta = 0;
        m_erros++;
        if (m_erros >= MAXE) begin
          m_erros = 0; m_bloq = BLOQ; m_decor = 0;
        end
      end else if (g) begin
        m_porta = ABRE; m_erros = 0;
      end else if (m_porta > 0) begin
        m_porta--;
      end
    end
  end

  task automatic chk(input string nome, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at %0t", nome, got, exp, $time);
    end
  endtask

  always @(posedge clock) begin
    #1;
    chk("porta_aberta", 32'(porta_aberta), 32'(m_porta > 0));
    chk("bloqueado", 32'(bloqueado), 32'(m_bloq > 0));
    chk("alarme", 32'(alarme), 32'((m_bloq > 0) && ((m_decor / PISCA) % 2 == 0)));
    chk("erros", 32'(erros), 32'(m_erros));
  end

  task automatic ciclos(input int n);
    repeat (n) @(negedge clock);
  endtask

  task automatic pulso(input bit verm, input bit verde);
    led_vermelho = verm;
    led_verde = verde;
    @(negedge clock);
    led_vermelho = 1'b0;
    led_verde = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] padrao;
    int n_bloq;
    padrao = '0;
    n_bloq = 0;

    // Reset and idle
    ciclos(2);
    reset_n = 1'b1;
    ciclos(20);
    chk("idle porta", 32'(porta_aberta), 0);
    chk("idle bloq", 32'(bloqueado), 0);
    chk("idle alarme", 32'(alarme), 0);
    chk("idle erros", 32'(erros), 0);

    // Single green: door for exactly 8 cycles
    pulso(0, 1);
    chk("porta ciclo1", 32'(porta_aberta), 1);
    ciclos(7);
    chk("porta ciclo8", 32'(porta_aberta), 1);
    ciclos(1);
    chk("porta ciclo9", 32'(porta_aberta), 0);

    // Red, red, green spaced 7 cycles
    ciclos(3);
    pulso(1, 0);
    chk("erros apos 1 verm", 32'(erros), 1);
    ciclos(6);
    pulso(1, 0);
    chk("erros apos 2 verm", 32'(erros), 2);
    ciclos(6);
    pulso(0, 1);
    chk("erros apos verde", 32'(erros), 0);
    chk("porta apos verde", 32'(porta_aberta), 1);
    ciclos(10);

    // Retrigger extends the door window
    pulso(0, 1);
    ciclos(4);
    pulso(0, 1);
    ciclos(7);
    chk("retrigger porta", 32'(porta_aberta), 1);
    ciclos(1);
    chk("retrigger fim", 32'(porta_aberta), 0);
    ciclos(3);

    // Three reds: lockout, blink pattern, green ignored mid-lockout
    pulso(1, 0); ciclos(1);
    pulso(1, 0); ciclos(1);
    pulso(1, 0);
    chk("bloqueio erros", 32'(erros), 0);
    for (int i = 0; i < 16; i++) begin
      padrao[15-i] = alarme;
      if (bloqueado) n_bloq++;
      if (i == 5) led_verde = 1'b1;
      if (i == 6) led_verde = 1'b0;
      @(negedge clock);
    end
    chk("padrao alarme", 32'(padrao), 32'h0000F0F0);
    chk("ciclos bloqueado", n_bloq, 16);
    chk("fim bloqueio", 32'(bloqueado), 0);
    pulso(0, 1);
    chk("verde apos bloqueio", 32'(porta_aberta), 1);

    // Red while open: back to idle with one error
    ciclos(2);
    pulso(1, 0);
    chk("verm em aberto porta", 32'(porta_aberta), 0);
    chk("verm em aberto erros", 32'(erros), 1);
    pulso(0, 1);
    ciclos(10);

    // Both strobes together count as an error; held red is a single event
    led_vermelho = 1'b1;
    led_verde = 1'b1;
    @(negedge clock);
    led_verde = 1'b0;
    chk("ambos erros", 32'(erros), 1);
    chk("ambos porta", 32'(porta_aberta), 0);
    ciclos(9);
    led_vermelho = 1'b0;
    chk("verm mantido erros", 32'(erros), 1);
    ciclos(2);
    pulso(0, 1);
    ciclos(10);

    // Reset in the middle of lockout
    pulso(1, 0); ciclos(1);
    pulso(1, 0); ciclos(1);
    pulso(1, 0);
    ciclos(7);
    chk("bloq antes reset", 32'(bloqueado), 1);
    reset_n = 1'b0;
    @(negedge clock);
    reset_n = 1'b1;
    chk("reset bloq", 32'(bloqueado), 0);
    chk("reset alarme", 32'(alarme), 0);
    chk("reset porta", 32'(porta_aberta), 0);
    chk("reset erros", 32'(erros), 0);
    ciclos(5);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
